// File: rtl/comparator_seq.sv
// comparator_seq: multi-cycle magnitude comparator that walks the operands CHUNK bits per
// cycle, least-significant chunk first, seeded by a cascade result from a lower stage.
//
// Optional feature: define COMPARATOR_SEQ_SIGNED_EN to add the signed_mode port, which
// selects a two's-complement compare for the accepted operand set.
//
// Ports:
//   clk, rst_n           clock (rising edge), asynchronous active-low reset
//   in_valid, in_ready   operand/seed handshake; in_ready is high only in IDLE
//   A, B                 WIDTH-bit operands
//   l, e, g              cascade seed (less / equal / greater)
//   signed_mode          (signed build only) two's-complement compare, sampled at accept
//   out_valid, out_ready result handshake; out_valid is high only in DONE
//   lt, et, gt           one-hot result, updated only on entry to DONE
//   busy                 high in RUN and DONE
module comparator_seq #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CHUNK = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             l,
  input  logic             e,
  input  logic             g,
`ifdef COMPARATOR_SEQ_SIGNED_EN
  input  logic             signed_mode,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic             lt,
  output logic             et,
  output logic             gt,
  output logic             busy
);

  localparam int unsigned NCHUNK = (WIDTH + CHUNK - 1) / CHUNK;
  localparam int unsigned PadW   = NCHUNK * CHUNK;
  // Index runs 0..NCHUNK; the value NCHUNK marks the final cycle that publishes the result.
  localparam int unsigned IdxW   = $clog2(NCHUNK + 1);

  // Result encodings, ordered {less, equal, greater}.
  localparam logic [2:0] ResLt = 3'b100;
  localparam logic [2:0] ResEq = 3'b010;
  localparam logic [2:0] ResGt = 3'b001;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e            state_q, state_d;
  logic [PadW-1:0]   a_q, a_d;
  logic [PadW-1:0]   b_q, b_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [2:0]        run_q, run_d;
  logic [2:0]        res_q, res_d;

  logic [PadW-1:0]   a_ext, b_ext;
  logic [2:0]        seed_norm;
  logic [CHUNK-1:0]  a_chunk, b_chunk;

  // Operands are kept as shift registers, so the current chunk is always the low CHUNK bits.
  assign a_chunk = a_q[CHUNK-1:0];
  assign b_chunk = b_q[CHUNK-1:0];

  always_comb begin
    unique case ({l, e, g})
      ResLt, ResEq, ResGt: seed_norm = {l, e, g};
      default:             seed_norm = ResEq;
    endcase
  end

  always_comb begin
    a_ext = '0;
    b_ext = '0;
    a_ext[WIDTH-1:0] = A;
    b_ext[WIDTH-1:0] = B;
`ifdef COMPARATOR_SEQ_SIGNED_EN
    // Flipping the sign bits maps two's-complement order onto unsigned order.
    if (signed_mode) begin
      a_ext[WIDTH-1] = ~A[WIDTH-1];
      b_ext[WIDTH-1] = ~B[WIDTH-1];
    end
`endif
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    idx_d   = idx_q;
    run_d   = run_q;
    res_d   = res_q;

    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          a_d     = a_ext;
          b_d     = b_ext;
          idx_d   = '0;
          run_d   = seed_norm;
          state_d = StRun;
        end
      end
      StRun: begin
        if (idx_q == IdxW'(NCHUNK)) begin
          res_d   = run_q;
          state_d = StDone;
        end else begin
          // Later (more significant) chunks overwrite earlier decisions; equal keeps them.
          if (a_chunk > b_chunk) begin
            run_d = ResGt;
          end else if (a_chunk < b_chunk) begin
            run_d = ResLt;
          end
          a_d   = a_q >> CHUNK;
          b_d   = b_q >> CHUNK;
          idx_d = idx_q + IdxW'(1);
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      idx_q   <= '0;
      run_q   <= ResEq;
      res_q   <= ResEq;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      idx_q   <= idx_d;
      run_q   <= run_d;
      res_q   <= res_d;
    end
  end

  assign in_ready     = (state_q == StIdle);
  assign out_valid    = (state_q == StDone);
  assign busy         = (state_q != StIdle);
  assign {lt, et, gt} = res_q;

endmodule

// File: tb/tb_comparator_seq.sv
// Testbench for comparator_seq (WIDTH=8, CHUNK=3): directed cases plus randomized operand
// sets checked against a numeric reference model.
module tb_comparator_seq;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned CHUNK = 3;
  localparam int unsigned NCHUNK = 3;

`ifdef COMPARATOR_SEQ_SIGNED_EN
  localparam bit SignedBuild = 1'b1;
`else
  localparam bit SignedBuild = 1'b0;
`endif

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             l, e, g;
  logic             signed_mode;
  logic             out_valid;
  logic             out_ready;
  logic             lt, et, gt;
  logic             busy;

  int n_checks;
  int n_errors;

  comparator_seq #(
    .WIDTH (WIDTH),
    .CHUNK (CHUNK)
  ) u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .A           (A),
    .B           (B),
    .l           (l),
    .e           (e),
    .g           (g),
`ifdef COMPARATOR_SEQ_SIGNED_EN
    .signed_mode (signed_mode),
`endif
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .lt          (lt),
    .et          (et),
    .gt          (gt),
    .busy        (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: numeric compare decides unless operands are equal, then the normalized seed.
  function automatic logic [2:0] model(input logic [7:0] a, input logic [7:0] b,
                                       input logic [2:0] seed, input logic sm);
    int ia, ib;
    if (sm) begin
      ia = int'($signed(a));
      ib = int'($signed(b));
    end else begin
      ia = int'({24'd0, a});
      ib = int'({24'd0, b});
    end
    if (ia < ib) return 3'b100;
    if (ia > ib) return 3'b001;
    if (seed == 3'b100 || seed == 3'b010 || seed == 3'b001) return seed;
    return 3'b010;
  endfunction

  // Called and returns at a falling edge with the DUT idle.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic [2:0] seed,
                        input logic sm, input int hold);
    logic [2:0] exp;
    int lat;
    exp = model(a, b, seed, sm);
    check("in_ready_before_accept", in_ready, 1);
    A = a;
    B = b;
    {l, e, g} = seed;
    signed_mode = sm;
    in_valid = 1'b1;
    out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      check("busy_run", {in_ready, busy}, 2'b01);
      // Operand/seed churn and stray in_valid while busy must be ignored.
      A = 8'($urandom);
      B = 8'($urandom);
      {l, e, g} = 3'($urandom);
      in_valid = 1'($urandom_range(0, 1));
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
    check("latency", lat, NCHUNK + 1);
    check("result", {lt, et, gt}, exp);
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      @(posedge clk);
      @(negedge clk);
      check("hold_result", {lt, et, gt}, exp);
      check("hold_flags", {out_valid, in_ready, busy}, 3'b101);
    end
    // Handshake edge with in_valid high: no accept may happen on it.
    out_ready = 1'b1;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    in_valid = 1'b0;
    check("after_handshake", {out_valid, in_ready, busy}, 3'b010);
    check("idle_holds_result", {lt, et, gt}, exp);
  endtask

  initial begin
    logic [7:0] ra, rb;
    logic [2:0] rseed;
    logic       rsm;
    n_checks = 0;
    n_errors = 0;
    rst_n = 1'b0;
    in_valid = 1'b0;
    A = '0;
    B = '0;
    {l, e, g} = 3'b000;
    signed_mode = 1'b0;
    out_ready = 1'b0;

    @(negedge clk);
    @(negedge clk);
    check("reset_flags", {out_valid, in_ready, busy}, 3'b010);
    check("reset_result", {lt, et, gt}, 3'b010);
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("in_ready_after_release", in_ready, 1);

    // Directed cases.
    run_op(8'hA5, 8'h5A, 3'b010, 1'b0, 0);
    run_op(8'h3C, 8'h3C, 3'b100, 1'b0, 0);
    run_op(8'h3C, 8'h3C, 3'b101, 1'b0, 0);
    run_op(8'h3C, 8'h3C, 3'b000, 1'b0, 0);
    run_op(8'h3C, 8'h3C, 3'b001, 1'b0, 0);
    run_op(8'h81, 8'h80, 3'b010, 1'b0, 0);
    run_op(8'h41, 8'h80, 3'b010, 1'b0, 0);
    run_op(8'hA5, 8'h5A, 3'b100, 1'b0, 5);
    if (SignedBuild) begin
      run_op(8'hFF, 8'h01, 3'b010, 1'b1, 0);
      run_op(8'hFF, 8'h01, 3'b010, 1'b0, 0);
    end

    // Reset in the middle of RUN, after a prior lt result so et is known low.
    run_op(8'h41, 8'h80, 3'b010, 1'b0, 0);
    A = 8'hA5;
    B = 8'h5A;
    {l, e, g} = 3'b010;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrun_reset_flags", {out_valid, in_ready, busy}, 3'b010);
    check("midrun_reset_result", {lt, et, gt}, 3'b010);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      @(negedge clk);
      check("no_result_after_abort", {out_valid, in_ready}, 2'b01);
    end

    // Randomized operand sets.
    for (int n = 0; n < 40; n++) begin
      ra = 8'($urandom);
      rb = ($urandom_range(0, 3) == 0) ? ra : 8'($urandom);
      rseed = 3'($urandom);
      rsm = SignedBuild ? 1'($urandom_range(0, 1)) : 1'b0;
      run_op(ra, rb, rseed, rsm, $urandom_range(0, 2));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
